// File: rtl/sine_seq_pkg.sv
// sine_seq_pkg: shared widths, FSM states and
// FIFO entry layout for the sine request sequencer.
package sine_seq_pkg;

  localparam int SEQ_EXP_LEN  = 8;
  localparam int SEQ_MANT_LEN = 23;
  localparam int SEQ_FLOAT_W  = SEQ_EXP_LEN + SEQ_MANT_LEN + 1;
  localparam int SEQ_IDX_W    = 16;
  localparam int EXP_BIAS     = (1 << (SEQ_EXP_LEN - 1)) - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_COS,
    S_ISSUE_SIN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [SEQ_FLOAT_W-1:0] cos;
    logic [SEQ_FLOAT_W-1:0] sin;
    logic [SEQ_IDX_W-1:0]   index;
    logic                   last;
  } fifo_entry_t;

endpackage

// File: rtl/index_to_float.sv
// index_to_float: exact conversion of a fixed-point
// index k * 2^-FRAC_BITS into float bits.
module index_to_float
  import sine_seq_pkg::*;
#(
  parameter int EXP_LEN      = SEQ_EXP_LEN,
  parameter int MANTISSA_LEN = SEQ_MANT_LEN,
  parameter int IDX_W        = SEQ_IDX_W,
  parameter int FRAC_BITS    = 12
) (
  input  logic [IDX_W-1:0]              k,
  output logic [EXP_LEN+MANTISSA_LEN:0] f
);

  localparam int BIAS = (1 << (EXP_LEN - 1)) - 1;

  int                    msb;
  logic [MANTISSA_LEN:0] aligned;
  logic [EXP_LEN-1:0]    exp_v;

  always_comb begin
    msb = 0;
    for (int i = 0; i < IDX_W; i++) begin
      if (k[i]) msb = i;
    end
    // leading one lands on the hidden bit
    aligned = (MANTISSA_LEN+1)'(k) << (MANTISSA_LEN - msb);
    exp_v   = EXP_LEN'(BIAS + msb - FRAC_BITS);
    f       = '0;
    if (k != '0) f = {1'b0, exp_v, aligned[MANTISSA_LEN-1:0]};
  end

endmodule

// File: rtl/sine_request_sequencer.sv
// sine_request_sequencer: issues cos/sin requests per
// index, pairs results, and queues them for the consumer.
module sine_request_sequencer
  import sine_seq_pkg::*;
#(
  parameter int EXP_LEN      = SEQ_EXP_LEN,
  parameter int MANTISSA_LEN = SEQ_MANT_LEN,
  parameter int IDX_W        = SEQ_IDX_W,
  parameter int FRAC_BITS    = 12,
  parameter int CALC_LATENCY = 3,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [IDX_W-1:0]              num_points,
  output logic                          busy,
  output logic                          done,
  output logic                          calc_enable,
  output logic [EXP_LEN+MANTISSA_LEN:0] calc_theta,
  output logic                          calc_sine_cosine,
  input  logic [EXP_LEN+MANTISSA_LEN:0] calc_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_LEN+MANTISSA_LEN:0] out_cos,
  output logic [EXP_LEN+MANTISSA_LEN:0] out_sin,
  output logic [IDX_W-1:0]              out_index,
  output logic                          out_last
);

  localparam int FW = EXP_LEN + MANTISSA_LEN + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int L  = CALC_LATENCY;

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d, n_q, n_d;
  logic [CW-1:0]     pif_q, pif_d, cnt_q, cnt_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic              seen_q, seen_d;
  logic [FW-1:0]     cos_q, cos_d;
  logic [L-1:0]      pv_q, pv_d, ps_q, ps_d;
  logic [L-1:0]      pl_q, pl_d;
  logic [IDX_W-1:0]  pk_q [L];
  logic [IDX_W-1:0]  pk_d [L];
  fifo_entry_t       mem_q [FIFO_DEPTH];
  fifo_entry_t       head, wr_entry;
  logic [FW-1:0]     theta;
  logic              is_last, credit, issue;
  logic              push, pop, pop_last;

  index_to_float #(
    .EXP_LEN      (EXP_LEN),
    .MANTISSA_LEN (MANTISSA_LEN),
    .IDX_W        (IDX_W),
    .FRAC_BITS    (FRAC_BITS)
  ) u_i2f (
    .k (k_q),
    .f (theta)
  );

  always_comb begin
    head     = mem_q[rd_q];
    is_last  = (k_q == n_q - IDX_W'(1));
    // in-flight pairs already own a FIFO slot
    credit   = ({1'b0, cnt_q} + {1'b0, pif_q})
               < (CW+1)'(FIFO_DEPTH);
    pop      = (cnt_q != '0) && out_ready;
    pop_last = pop && head.last;
    push     = pv_q[L-1] && ps_q[L-1];
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wr_d     = wr_q + PW'(push);
    rd_d     = rd_q + PW'(pop);
    wr_entry = '{cos: cos_q, sin: calc_value,
                 index: pk_q[L-1], last: pl_q[L-1]};
    cos_d    = cos_q;
    if (pv_q[L-1] && !ps_q[L-1]) cos_d = calc_value;

    state_d          = state_q;
    k_d              = k_q;
    n_d              = n_q;
    seen_d           = seen_q || pop_last;
    issue            = 1'b0;
    calc_sine_cosine = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = num_points;
          k_d     = '0;
          seen_d  = 1'b0;
          state_d = (num_points == '0) ? S_DONE
                                       : S_ISSUE_COS;
        end
      end
      S_ISSUE_COS: begin
        if (credit) begin
          issue   = 1'b1;
          state_d = S_ISSUE_SIN;
        end
      end
      S_ISSUE_SIN: begin
        issue            = 1'b1;
        calc_sine_cosine = 1'b1;
        if (is_last) begin
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + IDX_W'(1);
          state_d = S_ISSUE_COS;
        end
      end
      S_DRAIN: begin
        if (pif_q == '0 && cnt_d == '0 && seen_d)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pif_d = pif_q + CW'(issue && !calc_sine_cosine)
                  - CW'(push);

    pv_d[0] = issue;
    ps_d[0] = calc_sine_cosine;
    pl_d[0] = is_last;
    pk_d[0] = k_q;
    for (int i = 1; i < L; i++) begin
      pv_d[i] = pv_q[i-1];
      ps_d[i] = ps_q[i-1];
      pl_d[i] = pl_q[i-1];
      pk_d[i] = pk_q[i-1];
    end

    calc_enable = issue;
    calc_theta  = issue ? theta : '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    out_valid   = (cnt_q != '0);
    out_cos     = out_valid ? head.cos   : '0;
    out_sin     = out_valid ? head.sin   : '0;
    out_index   = out_valid ? head.index : '0;
    out_last    = out_valid && head.last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      pif_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      seen_q  <= 1'b0;
      cos_q   <= '0;
      pv_q    <= '0;
      ps_q    <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      pif_q   <= pif_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      seen_q  <= seen_d;
      cos_q   <= cos_d;
      pv_q    <= pv_d;
      ps_q    <= ps_d;
      pl_q    <= pl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_q] <= wr_entry;
    pk_q <= pk_d;
  end

endmodule

// File: tb/tb_sine_request_sequencer.sv
// tb_sine_request_sequencer: directed and randomized
// checks of request order, pairing, timing and reset.
module tb_sine_request_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] num_points = '0;
  logic        busy, done, calc_enable, calc_sine_cosine;
  logic        out_valid, out_last;
  logic [31:0] calc_theta, calc_value, out_cos, out_sin;
  logic [15:0] out_index;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  sine_request_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .num_points       (num_points),
    .busy             (busy),
    .done             (done),
    .calc_enable      (calc_enable),
    .calc_theta       (calc_theta),
    .calc_sine_cosine (calc_sine_cosine),
    .calc_value       (calc_value),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_cos          (out_cos),
    .out_sin          (out_sin),
    .out_index        (out_index),
    .out_last         (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fcos(input logic [31:0] t);
    return t ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] fsin(input logic [31:0] t);
    return {t[15:0], t[31:16]} ^ 32'h2468_ACE0;
  endfunction

  // stand-in calculator: 3-cycle latency, junk when idle
  logic [31:0] s1, s2, s3;
  always @(posedge clk) begin
    if (calc_enable)
      s1 <= calc_sine_cosine ? fsin(calc_theta)
                             : fcos(calc_theta);
    else
      s1 <= $urandom;
    s2 <= s1;
    s3 <= s2;
  end
  assign calc_value = s3;

  function automatic logic [31:0] to_float(input int k);
    int p;
    int e;
    int m;
    if (k == 0) return 32'h0;
    p = 0;
    while ((k >> (p + 1)) != 0) p++;
    e = 127 + p - 12;
    m = (k - (1 << p)) << (23 - p);
    return {1'b0, e[7:0], m[22:0]};
  endfunction

  typedef struct {
    int          cyc;
    logic [31:0] theta;
    logic        sc;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] c;
    logic [31:0] s;
    logic [15:0] idx;
    logic        last;
  } out_t;

  req_t req_q[$];
  out_t out_q[$];
  int   done_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (calc_enable)
        req_q.push_back('{cyc, calc_theta, calc_sine_cosine});
      if (out_valid && out_ready)
        out_q.push_back('{cyc, out_cos, out_sin,
                          out_index, out_last});
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, output int s);
    num_points = 16'(n);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input bit rnd,
                           input int db);
    for (int i = 0; i < lim; i++) begin
      tick();
      if (rnd) out_ready = ($urandom_range(0, 9) < 7);
      if (done_q.size() > db) break;
    end
    chk("done_seen", 64'(done_q.size() > db), 1);
    chk("busy_after", busy, 0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ":busy"}, busy, 0);
    chk({nm, ":done"}, done, 0);
    chk({nm, ":en"}, calc_enable, 0);
    chk({nm, ":theta"}, calc_theta, 0);
    chk({nm, ":sc"}, calc_sine_cosine, 0);
    chk({nm, ":valid"}, out_valid, 0);
    chk({nm, ":cos"}, out_cos, 0);
    chk({nm, ":sin"}, out_sin, 0);
    chk({nm, ":index"}, out_index, 0);
    chk({nm, ":last"}, out_last, 0);
  endtask

  task automatic check_run(input string nm, input int n,
                           input int rb, input int ob,
                           input int db);
    chk({nm, ":nreq"}, 64'(req_q.size() - rb), 64'(2 * n));
    for (int i = 0; i < 2 * n && rb + i < req_q.size(); i++) begin
      chk({nm, ":theta"}, req_q[rb+i].theta, to_float(i / 2));
      chk({nm, ":sc"}, req_q[rb+i].sc, 64'(i % 2));
    end
    chk({nm, ":nout"}, 64'(out_q.size() - ob), 64'(n));
    for (int i = 0; i < n && ob + i < out_q.size(); i++) begin
      chk({nm, ":idx"}, out_q[ob+i].idx, 64'(i));
      chk({nm, ":cos"}, out_q[ob+i].c, fcos(to_float(i)));
      chk({nm, ":sin"}, out_q[ob+i].s, fsin(to_float(i)));
      chk({nm, ":last"}, out_q[ob+i].last, 64'(i == n - 1));
    end
    chk({nm, ":ndone"}, 64'(done_q.size() - db), 1);
    if (n > 0 && out_q.size() > ob && done_q.size() > db)
      chk({nm, ":done_cyc"}, 64'(done_q[db]),
          64'(out_q[out_q.size()-1].cyc + 1));
  endtask

  logic [31:0] lit [8];
  int rb, ob, db, s, n;
  logic any;

  initial begin
    lit = '{32'h0, 32'h0, 32'h3980_0000, 32'h3980_0000,
            32'h3A00_0000, 32'h3A00_0000,
            32'h3A40_0000, 32'h3A40_0000};
    reset = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    out_ready = 1'b1;
    tick();

    // basic run, free-flowing consumer
    rb = req_q.size(); ob = out_q.size(); db = done_q.size();
    do_start(4, s);
    chk("A:busy", busy, 1);
    wait_done(100, 1'b0, db);
    check_run("A", 4, rb, ob, db);
    for (int i = 0; i < 8 && rb + i < req_q.size(); i++) begin
      chk("A:lit_theta", req_q[rb+i].theta, lit[i]);
      chk("A:req_cyc", 64'(req_q[rb+i].cyc), 64'(s + 1 + i));
    end
    for (int i = 0; i < 4 && ob + i < out_q.size(); i++)
      chk("A:out_cyc", 64'(out_q[ob+i].cyc), 64'(s + 6 + 2 * i));
    if (done_q.size() > db)
      chk("A:done_at", 64'(done_q[db]), 64'(s + 13));

    // back-pressure: credits cap issue at FIFO depth
    tick();
    out_ready = 1'b0;
    rb = req_q.size(); ob = out_q.size(); db = done_q.size();
    do_start(20, s);
    repeat (60) tick();
    chk("B:nreq_cap", 64'(req_q.size() - rb), 16);
    repeat (20) tick();
    chk("B:stall", 64'(req_q.size() - rb), 16);
    chk("B:en_low", calc_enable, 0);
    chk("B:valid", out_valid, 1);
    chk("B:head_idx", out_index, 0);
    wait_done(3000, 1'b1, db);
    check_run("B", 20, rb, ob, db);

    // randomized lengths and consumer stalls
    for (int r = 0; r < 3; r++) begin
      tick();
      n = $urandom_range(1, 24);
      rb = req_q.size(); ob = out_q.size(); db = done_q.size();
      do_start(n, s);
      wait_done(3000, 1'b1, db);
      check_run("R", n, rb, ob, db);
    end

    // empty sequence
    tick();
    out_ready = 1'b1;
    rb = req_q.size(); ob = out_q.size(); db = done_q.size();
    do_start(0, s);
    wait_done(20, 1'b0, db);
    check_run("Z", 0, rb, ob, db);
    if (done_q.size() > db)
      chk("Z:done_at", 64'(done_q[db]), 64'(s + 1));

    // reset with two pairs in flight
    tick();
    do_start(10, s);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midrst");
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      any = any | out_valid | calc_enable | busy;
    end
    chk("midrst:quiet", any, 0);
    rb = req_q.size(); ob = out_q.size(); db = done_q.size();
    do_start(3, s);
    wait_done(100, 1'b0, db);
    check_run("RS2", 3, rb, ob, db);

    // start while busy is ignored
    tick();
    rb = req_q.size(); ob = out_q.size(); db = done_q.size();
    do_start(5, s);
    tick();
    num_points = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, 1'b0, db);
    check_run("SB", 5, rb, ob, db);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sine_request_sequencer.md
# sine_request_sequencer

Initiator for the 3-cycle `sine_calculator` pipeline. On `start`, it converts angle indices k = 0..num_points-1 (fixed-point, k·2^-FRAC_BITS) to IEEE-style floats and issues one cosine request and one sine request per index. It tracks the pipeline's in-flight requests, pairs the returned values, and delivers {cos, sin, index} through a credit-protected output FIFO with a valid/ready handshake. It sits between the twiddle-factor consumer and the sine calculator instance.

## Interface
- EXP_LEN, 8, float exponent width
- MANTISSA_LEN, 23, float mantissa width
- IDX_W, 16, index width; must satisfy IDX_W ≤ MANTISSA_LEN+1
- FRAC_BITS, 12, fixed-point fraction bits of the angle index
- CALC_LATENCY, 3, request-to-result latency of `sine_calculator`
- FIFO_DEPTH, 8, output FIFO depth in pairs; must be a power of two
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a sequence; sampled only in IDLE
- num_points  in  IDX_W  number of indices to generate
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at sequence end
- calc_enable  out  1  to `sine_calculator.enable`
- calc_theta  out  EXP_LEN+MANTISSA_LEN+1  to `inp_theta`
- calc_sine_cosine  out  1  to `inp_sine_cosine`; 0 = cos, 1 = sin
- calc_value  in  EXP_LEN+MANTISSA_LEN+1  from `out_value`
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head
- out_cos, out_sin  out  EXP_LEN+MANTISSA_LEN+1 each  result pair
- out_index  out  IDX_W  k of the pair
- out_last  out  1  marks the pair with k = num_points-1

## Operation
- FSM states: IDLE, ISSUE_COS, ISSUE_SIN, DRAIN, DONE.
  - IDLE→ISSUE_COS on start when num_points≠0.
  - IDLE→DONE on start when num_points=0.
- ISSUE_COS issues only if fifo_count + pairs_in_flight < FIFO_DEPTH; otherwise it stalls with calc_enable=0.
- ISSUE_COS→ISSUE_SIN always after an issue.
- ISSUE_SIN→ISSUE_COS with k+1, or →DRAIN after the last k.
- DRAIN→DONE when pairs_in_flight=0, FIFO empty, and the final pair has been handshaken.
- DONE→IDLE after one cycle; done=1 in the DONE cycle only.
- calc_enable=1 only in cycles that issue a request. calc_theta and calc_sine_cosine are don't-care otherwise but are driven to 0.
- Index-to-float conversion:
  - k=0 gives all-zero bits.
  - Otherwise, with p = MSB position of k: sign=0, exp = (2^(EXP_LEN-1)-1) + p - FRAC_BITS, mantissa = bits below the leading one, left-aligned.
  - The result is exact.
- Valid tracking: a CALC_LATENCY-deep shift register carries {valid, is_sin, k} alongside the pipeline.
  - A cos result is held in a register.
  - A sin result writes {held cos, calc_value, k, last} into the FIFO.
- pairs_in_flight increments on cos issue and decrements on FIFO write. The credit check makes FIFO overflow impossible.
- FIFO pop happens on out_valid & out_ready. A simultaneous push and pop in one cycle is legal; count is unchanged.
- start while busy is ignored.
- Reset, including mid-sequence:
  - FSM→IDLE; FIFO, counters and valid pipe cleared.
  - Results returning after reset are discarded.
  - All outputs are 0.

## Timing
- Cycle n = interval after clock edge n. A request issued in cycle c has calc_value valid in cycle c+CALC_LATENCY.
- start high in cycle 0, FIFO free:
  - cos k=0 issued in cycle 1, sin k=0 in cycle 2.
  - Results arrive in cycles 4 and 5; FIFO write at edge 6.
  - out_valid=1 in cycle 6.
- Throughput: one pair per 2 cycles when not back-pressured.
- done asserts 1 cycle after the last pair's handshake cycle, or in cycle 1 when num_points=0.
- Reset values: busy=0, done=0, calc_enable=0, calc_theta=0, calc_sine_cosine=0, out_valid=0, out_cos=0, out_sin=0, out_index=0, out_last=0.

## Structure
- Package `sine_seq_pkg` holds:
  - float width constants and EXP_BIAS;
  - the FSM state enum;
  - the packed FIFO entry struct {cos, sin, index, last}.
- Sub-module `index_to_float`: combinational priority encoder plus shifter (k → float bits).
- The FIFO is inline: register array with wrap-around read/write pointers and a count.

## Test plan
- FRAC_BITS=12, num_points=4, out_ready=1:
  - calc_theta sequence: 0x00000000 ×2, 0x39800000 ×2, 0x3A000000 ×2, 0x3A400000 ×2 (cos then sin each).
  - calc_sine_cosine toggles 0,1.
- Latency check: start in cycle 0 → first out_valid in cycle 6 with out_index=0; out_last=1 only on index 3; done 1 cycle after the last handshake.
- Back-pressure: out_ready=0, num_points=20 → exactly 8 pairs issued, then calc_enable stays 0. Raising out_ready resumes; all 20 pairs arrive in order with no loss.
- num_points=0 → no calc_enable pulses, no out_valid, done in cycle 1.
- Reset asserted with 2 pairs in flight → all outputs 0 next cycle. Subsequently returning calc_value is ignored; a new start works normally.
- start pulsed while busy → ignored; the sequence count equals the original num_points.
